// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, state encoding and GF(2^8) helpers for the
//               AES-128 key-schedule engine.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;

    // Round constants; entry i is folded in when producing round key i+1.
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Out-of-table indices return zero so the lookup is total.
    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        logic [7:0] val;
        val = 8'h00;
        if (idx < 4'd10) begin
            val = RCON[idx];
        end
        return val;
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ acc;
            end
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // AES forward S-box: multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES byte S-box shared with the round datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_byte(in_byte);

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_sub_word
// Description : SubWord - applies the byte S-box to each byte of a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    for (genvar b = 0; b < WORD_W / 8; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (word_in[8*b +: 8]),
            .out_byte (word_out[8*b +: 8])
        );
    end

endmodule : aes_sub_word
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128 key schedule. Emits round keys 0..NR one per
//               valid/ready handshake, computing one round key per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] round_key,
    output logic             rk_valid,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t            state;
    state_t            state_next;
    logic [KEY_W-1:0]  key_reg;
    logic [KEY_W-1:0]  next_key;
    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot_w3;
    logic [WORD_W-1:0] sub_w3;
    logic [WORD_W-1:0] t_word;
    logic [WORD_W-1:0] n0, n1, n2, n3;
    logic              handshake;
    logic              last_key;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word_in  (rot_w3),
        .word_out (sub_w3)
    );

    assign t_word   = sub_w3 ^ {rcon_at(round_idx), 24'h000000};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign handshake = (state == EMIT) && rk_ready;
    assign last_key  = (round_idx == LAST_IDX);

    // Outputs come straight from registers; nothing from key_in or rk_ready
    // reaches round_key combinationally.
    assign round_key = key_reg;
    assign rk_valid  = (state == EMIT);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready && last_key) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Key register, round counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= '0;
            round_idx <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == IDLE) && start) begin
                key_reg   <= key_in;
                round_idx <= 4'd0;
            end else if (handshake) begin
                if (last_key) begin
                    done <= 1'b1;
                end else begin
                    key_reg   <= next_key;
                    round_idx <= round_idx + 4'd1;
                end
            end
        end
    end

endmodule : aes_key_expand
`default_nettype wire
